// File: rtl/nibble_merge_pkg.sv
// Shared types, nibble bounds and opcode helpers for the nibble merge sequencer.
// Latency: none (definitions only); backpressure: n/a.
package nibble_merge_pkg;

    typedef enum logic [2:0] {
        OP_NOP     = 3'd0,
        OP_LOAD_LO = 3'd1,
        OP_LOAD_HI = 3'd2,
        OP_CAT_AB  = 3'd3,
        OP_CAT_BA  = 3'd4,
        OP_CLEAR   = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_OUT  = 2'd2
    } state_e;

    localparam int LO_MSB   = 3;
    localparam int LO_LSB   = 0;
    localparam int HI_MSB   = 7;
    localparam int HI_LSB   = 4;
    localparam int BHI_MSB  = 6;
    localparam int BHI_LSB  = 3;
    localparam int C_MSB    = 3;
    localparam int C_LSB    = 2;

    typedef struct packed {
        logic [2:0] op;
        logic [7:0] a;
        logic [6:0] b;
    } cmd_t;

    function automatic logic op_illegal(input logic [2:0] op);
        return op > OP_CLEAR;
    endfunction

endpackage

// File: rtl/nibble_merge_sequencer_if.sv
// Request/result bundle between two requesters, the sequencer and its consumer.
// Latency: wires only; backpressure: out_ready stalls results, reqN_ready is a one-cycle accept.
interface nibble_merge_sequencer_if;
    logic       req0_valid;
    logic [2:0] req0_op;
    logic [7:0] req0_a;
    logic [6:0] req0_b;
    logic       req0_ready;

    logic       req1_valid;
    logic [2:0] req1_op;
    logic [7:0] req1_a;
    logic [6:0] req1_b;
    logic       req1_ready;

    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_d;
    logic [1:0] out_c;
    logic       out_src;
    logic       out_err;
    logic       busy;

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output out_ready,
        input  req0_ready, req1_ready,
        input  out_valid, out_d, out_c, out_src, out_err, busy
    );

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  out_ready,
        output req0_ready, req1_ready,
        output out_valid, out_d, out_c, out_src, out_err, busy
    );
endinterface

// File: rtl/rr_arbiter2.sv
// Two-way arbiter: round-robin on contention when RR_EN=1, else req0 always wins.
// Latency: combinational grant; backpressure: grants only while en is high.
module rr_arbiter2 #(
    parameter bit RR_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    // pref_q = 1 means requester 1 wins the next contended cycle
    logic pref_q;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req == 2'b11) begin
                gnt = (RR_EN && pref_q) ? 2'b10 : 2'b01;
            end else begin
                gnt = req;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pref_q <= 1'b0;
        end else if (RR_EN && (gnt != 2'b00)) begin
            pref_q <= gnt[0];
        end
    end

endmodule

// File: rtl/nibble_merge_sequencer.sv
// Arbitrates two requesters onto one nibble-merge datapath with a persistent byte d.
// Latency: accept at t -> out_valid at t+2; backpressure: holds result until out_ready, no accepts while busy.
module nibble_merge_sequencer
    import nibble_merge_pkg::*;
#(
    parameter bit         RR_EN   = 1'b1,
    parameter logic [7:0] D_RESET = 8'h00
) (
    input logic                     clk,
    input logic                     rst_n,
    nibble_merge_sequencer_if.slave bus
);

    state_e     state_q;
    state_e     state_d;
    cmd_t       cmd_q;
    logic       src_q;
    logic [7:0] d_q;
    logic [1:0] c_q;
    logic       src_out_q;
    logic       err_q;
    logic [1:0] gnt;
    logic       idle;

    function automatic logic [7:0] merge(input logic [2:0] op, input logic [7:0] d,
                                         input logic [7:0] a, input logic [6:0] b);
        logic [7:0] r;
        r = d;
        case (op)
            OP_LOAD_LO: r[LO_MSB:LO_LSB] = a[LO_MSB:LO_LSB];
            OP_LOAD_HI: r[HI_MSB:HI_LSB] = b[BHI_MSB:BHI_LSB];
            OP_CAT_AB:  r = {a[LO_MSB:LO_LSB], b[LO_MSB:LO_LSB]};
            OP_CAT_BA:  r = {b[LO_MSB:LO_LSB], a[HI_MSB:HI_LSB]};
            OP_CLEAR:   r = D_RESET;
            default:    r = d;
        endcase
        return r;
    endfunction

    assign idle = (state_q == ST_IDLE);

    // rst_n gating keeps ready quiet while reset is held with a valid request pending
    rr_arbiter2 #(.RR_EN(RR_EN)) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   ({bus.req1_valid, bus.req0_valid}),
        .en    (idle && rst_n),
        .gnt   (gnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (gnt != 2'b00) state_d = ST_EXEC;
            ST_EXEC: state_d = ST_OUT;
            ST_OUT:  if (bus.out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q     <= '0;
            src_q     <= 1'b0;
            d_q       <= D_RESET;
            c_q       <= 2'b00;
            src_out_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            if (idle && (gnt != 2'b00)) begin
                cmd_q <= gnt[1] ? '{op: bus.req1_op, a: bus.req1_a, b: bus.req1_b}
                                : '{op: bus.req0_op, a: bus.req0_a, b: bus.req0_b};
                src_q <= gnt[1];
            end
            if (state_q == ST_EXEC) begin
                d_q       <= merge(cmd_q.op, d_q, cmd_q.a, cmd_q.b);
                c_q       <= cmd_q.a[C_MSB:C_LSB];
                err_q     <= op_illegal(cmd_q.op);
                src_out_q <= src_q;
            end
        end
    end

    assign bus.req0_ready = gnt[0];
    assign bus.req1_ready = gnt[1];
    assign bus.out_valid  = (state_q == ST_OUT);
    assign bus.out_d      = d_q;
    assign bus.out_c      = c_q;
    assign bus.out_src    = src_out_q;
    assign bus.out_err    = err_q;
    assign bus.busy       = !idle;

endmodule
